// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the program-counter sequencer and its
// next-PC calculator.
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    FETCH     = 2'd0,
    WAIT_EXEC = 2'd1,
    HALTED    = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    NPC_SEQ = 2'd0,
    NPC_BR  = 2'd1,
    NPC_J   = 2'd2,
    NPC_JR  = 2'd3
  } npc_sel_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam int IMM16_LSB   = 0;
  localparam int IMM16_W     = 16;
  localparam int INDEX26_LSB = 0;
  localparam int INDEX26_W   = 26;

  // jump_reg outranks jump, which outranks a taken branch.
  function automatic npc_sel_e npc_select(input logic jr, input logic j, input logic br);
    if (jr) return NPC_JR;
    else if (j) return NPC_J;
    else if (br) return NPC_BR;
    return NPC_SEQ;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Instruction-memory fetch handshake between the sequencer and imem.
interface pc_sequencer_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/pc_sequencer_next_pc_calc.sv
// Combinational next-PC computation: sequential, branch, jump and register
// targets, all modulo 2^32.
module next_pc_calc
  import pc_sequencer_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  npc_sel_e    sel,
  input  logic [31:0] reg_target,
  output logic [31:0] next_pc,
  output logic [31:0] pc_plus4
);

  logic signed [31:0] br_off;
  logic               unused_opcode;

  assign pc_plus4      = pc + 32'd4;
  assign br_off        = {{14{instr[IMM16_LSB+IMM16_W-1]}}, instr[IMM16_LSB +: IMM16_W], 2'b00};
  assign unused_opcode = &instr[31:26];

  always_comb begin
    next_pc = pc_plus4;
    case (sel)
      NPC_SEQ: next_pc = pc_plus4;
      NPC_BR:  next_pc = pc_plus4 + $unsigned(br_off);
      NPC_J:   next_pc = {pc_plus4[31:28], instr[INDEX26_LSB +: INDEX26_W], 2'b00};
      NPC_JR:  next_pc = reg_target;
      default: next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle PC controller: fetch over req/ack, wait for the datapath to
// retire, then load the selected next PC or stop.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pc_sequencer_if.master        imem,
  output logic [31:0]           instr,
  output logic                  instr_valid,
  input  logic                  exec_done,
  input  logic                  branch_taken,
  input  logic                  jump,
  input  logic                  jump_reg,
  input  logic [31:0]           reg_target,
  input  logic                  halt,
  output logic [31:0]           pc,
  output logic [31:0]           pc_plus4,
  output logic                  halted,
  output logic                  misalign
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        req_q, req_d;
  logic        misalign_q, misalign_d;
  logic [31:0] next_pc;
  npc_sel_e    sel;

  assign sel = npc_select(jump_reg, jump, branch_taken);

  next_pc_calc u_next_pc_calc (
    .pc         (pc_q),
    .instr      (instr_q),
    .sel        (sel),
    .reg_target (reg_target),
    .next_pc    (next_pc),
    .pc_plus4   (pc_plus4)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    misalign_d = misalign_q;
    case (state_q)
      // An ack only counts while our own request is on the bus.
      FETCH: begin
        if (imem.ack && req_q) begin
          instr_d = imem.rdata;
          state_d = WAIT_EXEC;
        end
      end
      WAIT_EXEC: begin
        if (exec_done) begin
          if (jump_reg && (reg_target[1:0] != 2'b00)) begin
            misalign_d = 1'b1;
            state_d    = HALTED;
          end else begin
            pc_d    = next_pc;
            state_d = halt ? HALTED : FETCH;
          end
        end
      end
      HALTED:  state_d = HALTED;
      default: state_d = FETCH;
    endcase
    // Registered request: rises the cycle FETCH is entered, falls after ack.
    req_d = (state_d == FETCH);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      instr_q    <= 32'h0;
      req_q      <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      req_q      <= req_d;
      misalign_q <= misalign_d;
    end
  end

  assign imem.req    = req_q;
  assign imem.addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = (state_q == WAIT_EXEC);
  assign pc          = pc_q;
  assign halted      = (state_q == HALTED);
  assign misalign    = misalign_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: expected fetch addresses are queued
// as instructions retire and compared when the next request appears.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        exec_done = 1'b0;
  logic        branch_taken = 1'b0;
  logic        jump = 1'b0;
  logic        jump_reg = 1'b0;
  logic [31:0] reg_target = 32'h0;
  logic        halt = 1'b0;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        halted;
  logic        misalign;

  int          checks = 0;
  int          fails = 0;
  logic [31:0] m_pc;
  logic [31:0] cur_instr;
  logic [31:0] exp_addr_q[$];

  pc_sequencer_if imem_if ();

  pc_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem         (imem_if),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .exec_done    (exec_done),
    .branch_taken (branch_taken),
    .jump         (jump),
    .jump_reg     (jump_reg),
    .reg_target   (reg_target),
    .halt         (halt),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .halted       (halted),
    .misalign     (misalign)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] model_npc(input logic [31:0] p, input logic [31:0] ins,
                                            input logic br, input logic j, input logic jr,
                                            input logic [31:0] rt);
    logic [31:0] p4;
    logic [31:0] off;
    p4  = p + 32'd4;
    off = {{16{ins[15]}}, ins[15:0]} << 2;
    if (jr) return rt;
    if (j) return {p4[31:28], ins[25:0], 2'b00};
    if (br) return p4 + off;
    return p4;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_pc = 32'h0;
    exp_addr_q.delete();
    exp_addr_q.push_back(32'h0);
  endtask

  task automatic fetch(input logic [31:0] rdata, input int delay);
    int          n;
    logic [31:0] ea;
    n = 0;
    while (imem_if.req !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (imem_if.req !== 1'b1) begin
      fails++;
      $display("FAIL fetch_req_timeout: imem_req=%b required 1", imem_if.req);
      return;
    end
    checks++;
    if (exp_addr_q.size() == 0) begin
      fails++;
      $display("FAIL fetch_unexpected: request at %h with empty scoreboard", imem_if.addr);
      ea = imem_if.addr;
    end else begin
      ea = exp_addr_q.pop_front();
      if (imem_if.addr !== ea) begin
        fails++;
        $display("FAIL fetch_addr: imem_addr=%h required %h", imem_if.addr, ea);
      end
    end
    checks++;
    if (pc_plus4 !== ea + 32'd4) begin
      fails++;
      $display("FAIL pc_plus4: got %h required %h", pc_plus4, ea + 32'd4);
    end
    // exec_done with a misaligned jump_reg is thrown at the DUT while fetching.
    for (int i = 0; i < delay; i++) begin
      exec_done = 1'b1; jump_reg = 1'b1; reg_target = 32'h0000_0003;
      @(negedge clk);
      checks++;
      if (imem_if.req !== 1'b1 || imem_if.addr !== ea || misalign !== 1'b0) begin
        fails++;
        $display("FAIL fetch_hold: req=%b addr=%h misalign=%b required 1 %h 0",
                 imem_if.req, imem_if.addr, misalign, ea);
      end
    end
    exec_done = 1'b0; jump_reg = 1'b0; reg_target = 32'h0;
    imem_if.ack = 1'b1;
    imem_if.rdata = rdata;
    @(negedge clk);
    imem_if.ack = 1'b0;
    imem_if.rdata = 32'h0;
    checks++;
    if (instr_valid !== 1'b1 || instr !== rdata || imem_if.req !== 1'b0) begin
      fails++;
      $display("FAIL fetch_latch: valid=%b instr=%h req=%b required 1 %h 0",
               instr_valid, instr, imem_if.req, rdata);
    end
    cur_instr = rdata;
  endtask

  task automatic execute(input logic br, input logic j, input logic jr,
                         input logic [31:0] rt, input logic hlt);
    logic [31:0] exp_pc;
    logic        mis;
    mis = jr && (rt[1:0] != 2'b00);
    exp_pc = mis ? m_pc : model_npc(m_pc, cur_instr, br, j, jr, rt);
    exec_done = 1'b1; branch_taken = br; jump = j; jump_reg = jr; reg_target = rt; halt = hlt;
    @(negedge clk);
    exec_done = 1'b0; branch_taken = 1'b0; jump = 1'b0; jump_reg = 1'b0;
    reg_target = 32'h0; halt = 1'b0;
    checks++;
    if (pc !== exp_pc) begin
      fails++;
      $display("FAIL exec_pc: pc=%h required %h", pc, exp_pc);
    end
    checks++;
    if (instr_valid !== 1'b0 || halted !== (mis || hlt) || misalign !== mis) begin
      fails++;
      $display("FAIL exec_status: valid=%b halted=%b misalign=%b required 0 %b %b",
               instr_valid, halted, misalign, mis || hlt, mis);
    end
    m_pc = exp_pc;
    if (!(mis || hlt)) exp_addr_q.push_back(exp_pc);
  endtask

  task automatic check_halted_hold(input string tag);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (imem_if.req !== 1'b0 || instr_valid !== 1'b0 || halted !== 1'b1 || pc !== m_pc) begin
        fails++;
        $display("FAIL %s_hold: req=%b valid=%b halted=%b pc=%h required 0 0 1 %h",
                 tag, imem_if.req, instr_valid, halted, pc, m_pc);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (imem_if.req !== 1'b0 || pc !== 32'h0 || instr !== 32'h0 || instr_valid !== 1'b0 ||
        halted !== 1'b0 || misalign !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: req=%b pc=%h instr=%h valid=%b halted=%b misalign=%b required all 0",
               imem_if.req, pc, instr, instr_valid, halted, misalign);
    end
    do_reset();
    checks++;
    if (imem_if.req !== 1'b0) begin
      fails++;
      $display("FAIL reset_release_req: imem_req=%b required 0", imem_if.req);
    end
    @(negedge clk);
    checks++;
    if (imem_if.req !== 1'b1) begin
      fails++;
      $display("FAIL first_req: imem_req=%b required 1", imem_if.req);
    end
  endtask

  task automatic test_sequential();
    fetch(32'h2008_0001, 3);
    execute(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checks++;
    if (pc !== 32'h0000_0004 || imem_if.req !== 1'b1) begin
      fails++;
      $display("FAIL seq_pc: pc=%h req=%b required 00000004 1", pc, imem_if.req);
    end
  endtask

  task automatic test_branch();
    fetch(32'h0000_0000, 1);
    execute(1'b0, 1'b0, 1'b1, 32'h0000_0010, 1'b0);
    fetch(32'h1000_FFFC, 2);
    execute(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    checks++;
    if (pc !== 32'h0000_0004) begin
      fails++;
      $display("FAIL branch_back: pc=%h required 00000004", pc);
    end
  endtask

  task automatic test_jump();
    fetch(32'h0000_0000, 0);
    execute(1'b0, 1'b0, 1'b1, 32'h4000_0008, 1'b0);
    fetch(32'h0800_0040, 1);
    execute(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    checks++;
    if (pc !== 32'h4000_0100) begin
      fails++;
      $display("FAIL jump_priority: pc=%h required 40000100", pc);
    end
  endtask

  task automatic test_jump_reg();
    fetch(32'h0100_0008, 1);
    execute(1'b1, 1'b1, 1'b1, 32'h0000_0200, 1'b0);
    checks++;
    if (pc !== 32'h0000_0200) begin
      fails++;
      $display("FAIL jr_aligned: pc=%h required 00000200", pc);
    end
    fetch(32'h0100_0008, 0);
    execute(1'b0, 1'b0, 1'b1, 32'h0000_0202, 1'b0);
    checks++;
    if (misalign !== 1'b1 || halted !== 1'b1 || pc !== 32'h0000_0200) begin
      fails++;
      $display("FAIL jr_misalign: misalign=%b halted=%b pc=%h required 1 1 00000200",
               misalign, halted, pc);
    end
    check_halted_hold("misalign");
    checks++;
    if (misalign !== 1'b1) begin
      fails++;
      $display("FAIL misalign_sticky: misalign=%b required 1", misalign);
    end
  endtask

  task automatic test_wrap_halt();
    do_reset();
    checks++;
    if (misalign !== 1'b0 || halted !== 1'b0) begin
      fails++;
      $display("FAIL reset_clears: misalign=%b halted=%b required 0 0", misalign, halted);
    end
    fetch(32'h0000_0000, 0);
    execute(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    fetch(32'h2008_0001, 1);
    execute(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    checks++;
    if (pc !== 32'h0 || halted !== 1'b1 || misalign !== 1'b0) begin
      fails++;
      $display("FAIL wrap_halt: pc=%h halted=%b misalign=%b required 00000000 1 0",
               pc, halted, misalign);
    end
    check_halted_hold("halt");
    do_reset();
    fetch(32'h0000_0000, 1);
    execute(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) begin
      halt = 1'b1;
      fetch(32'h2000_0000 + k, 0);
      halt = 1'b0;
      execute(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      checks++;
      if (imem_if.req !== 1'b1 || halted !== 1'b0) begin
        fails++;
        $display("FAIL b2b_period: req=%b halted=%b required 1 0", imem_if.req, halted);
      end
    end
  endtask

  task automatic test_reset_mid_fetch();
    int n;
    fetch(32'h0000_0000, 0);
    execute(1'b0, 1'b0, 1'b1, 32'h0000_0080, 1'b0);
    n = 0;
    while (imem_if.req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (imem_if.req !== 1'b1 || imem_if.addr !== 32'h0000_0080) begin
      fails++;
      $display("FAIL midreset_pre: req=%b addr=%h required 1 00000080", imem_if.req, imem_if.addr);
    end
    rst_n = 1'b0;
    imem_if.ack = 1'b1;
    imem_if.rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++;
    if (imem_if.req !== 1'b0 || pc !== 32'h0 || instr !== 32'h0) begin
      fails++;
      $display("FAIL midreset_drop: req=%b pc=%h instr=%h required 0 00000000 00000000",
               imem_if.req, pc, instr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (instr !== 32'h0 || instr_valid !== 1'b0 || imem_if.req !== 1'b1) begin
      fails++;
      $display("FAIL late_ack_ignored: instr=%h valid=%b req=%b required 00000000 0 1",
               instr, instr_valid, imem_if.req);
    end
    imem_if.ack = 1'b0;
    imem_if.rdata = 32'h0;
    m_pc = 32'h0;
    exp_addr_q.delete();
    exp_addr_q.push_back(32'h0);
    fetch(32'h2008_0001, 2);
    execute(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    imem_if.ack = 1'b0;
    imem_if.rdata = 32'h0;
    m_pc = 32'h0;
    cur_instr = 32'h0;
    test_reset();
    test_sequential();
    test_branch();
    test_jump();
    test_jump_reg();
    test_wrap_halt();
    test_back_to_back();
    test_reset_mid_fetch();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
